mcycle_muldiv: RTL
==================

Name: mcycle_muldiv

Overview:
- Multi-cycle RV32M multiply/divide unit, sitting beside the ALU in the single-cycle core.
- Consumes the register-file read ports (rs1 on Operand1, rs2 on Operand2) and the M-extension funct3 on MCycleOp.
- Returns a WIDTH-bit result to the writeback mux.
- Busy feeds the core's stall logic: it holds the PC and suppresses RegWrite until Done.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
CLK  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only when Busy=0
MCycleOp  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
Operand1  input  WIDTH  rs1 value (multiplicand / dividend)
Operand2  input  WIDTH  rs2 value (multiplier / divisor)
Result  output  WIDTH  registered result, held until next completion
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse: Result updated this cycle

Behaviour:
- One clock, CLK. Reset is synchronous and active-high. Reset=1 at an edge forces state IDLE, Busy=0, Done=0, Result=0 and clears all internal registers.
- Reset mid-operation aborts the operation; no Done pulse follows.
- States: IDLE, RUN, FINISH.
- IDLE: Start=1 at an edge does the following, then moves to RUN:
  - Latch op and signedness flags.
  - Latch |Operand1| and |Operand2| for the signed operands only: MULH both, MULHSU Operand1 only, DIV/REM both.
  - Latch the result-sign flag.
  - Clear the 2*WIDTH accumulator; counter=0.
- RUN: one iteration per cycle; counter increments; after WIDTH iterations (counter==WIDTH-1) moves to FINISH.
  - Multiply: shift-add, 1 multiplier bit per cycle, LSB first.
  - Divide: restoring, 1 quotient bit per cycle, MSB first.
- FINISH (one cycle): applies sign correction and selects the result half. At the edge leaving FINISH, Result is registered and state returns to IDLE. Done=1 for exactly the following cycle.
- Timing: Start seen at edge E0 -> Busy=1 from E0 through edge E0+WIDTH+1 -> Busy=0 and Done=1 in the cycle after. Latency is uniform for all ops and all operand values.
- Start while Busy=1 is ignored; no queueing.
- Start=1 during the Done cycle is accepted (Busy=0). The new operation begins and Result keeps the old value until the next completion.
- Result selection:
  - MUL: low WIDTH bits of the product.
  - MULH/MULHSU/MULHU: high WIDTH bits. Negate the full 2*WIDTH product before slicing when the sign flag is set.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Remainder sign = dividend sign. Quotient sign = XOR of the operand signs.
- Special cases, resolved in FINISH with the same latency:
  - Divisor=0: DIV/DIVU quotient = all ones; REM/REMU = Operand1 unmodified.
  - Signed overflow (Operand1 = 0x80000000, Operand2 = 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- |0x80000000| is 0x80000000 treated as unsigned; the datapath is WIDTH+1 wide where needed so this is exact.
- Operand1, Operand2 and MCycleOp need not be held after the Start edge.

Decomposition:
- Shared package:
  - Op encodings (OP_MUL … OP_REMU as 3-bit localparams).
  - State enum (IDLE, RUN, FINISH).
  - Helper constants: DIV0_QUOT all-ones, signed overflow pattern.
- One natural sub-module, mcycle_negate: combinational two's-complement conditional negate, parameterised width. Instantiated for the operand abs-values (WIDTH) and the result fix-up (2*WIDTH).

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), Start for 1 cycle -> Busy high for exactly 34 cycles, then Done pulse with Result=0xFFFFFFEB; Busy=0 in the Done cycle.
- MULH/MULHSU/MULHU with 0x80000000 x 0xFFFFFFFF:
  - MULH -> 0x00000000
  - MULHSU -> 0x80000000
  - MULHU -> 0x7FFFFFFF
- DIV -7 / 2 -> Result=0xFFFFFFFD; REM -7 % 2 -> Result=0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5%0 -> 0x00000005.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Start pulsed again at cycle 10 of a running op -> ignored; first result unchanged.
  - Start asserted in the Done cycle -> second op accepted; its Done arrives 35 cycles later (34 cycles Busy plus the Done cycle); Result holds the first value meanwhile.
- Reset asserted at cycle 15 of a DIV -> next cycle Busy=0, Result=0; no Done pulse ever follows; a new Start after release completes normally.

Source files
------------

// File: rtl/mcycle_muldiv_pkg.sv
// Shared definitions for the multi-cycle RV32M multiply/divide unit:
// funct3 encodings, controller states and special-case result patterns.
package mcycle_muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;

    localparam logic [XLEN-1:0] DIV0_QUOT    = '1;
    localparam logic [XLEN-1:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [XLEN-1:0] OVF_DIVISOR  = '1;

endpackage

// File: rtl/mcycle_negate.sv
// Combinational conditional two's-complement negate.
module mcycle_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mcycle_muldiv.sv
// Multi-cycle RV32M multiply/divide: shift-add multiply, restoring divide on
// operand magnitudes, sign fix-up in FINISH, then one writeback cycle.
module mcycle_muldiv
    import mcycle_muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q;
    logic [2:0]         op_q;
    logic               neg_q, div0_q, ovf_q, wb_q, busy_q, done_q;
    logic [WIDTH-1:0]   a_q, b_q, op1_q, wb_res_q, result_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;

    // Operand decode at the Start edge
    logic             op1_signed, op2_signed, s1, s2, start_neg, start_ovf;
    logic [WIDTH-1:0] abs1, abs2;

    always_comb begin
        op1_signed = MCycleOp inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        op2_signed = MCycleOp inside {OP_MULH, OP_DIV, OP_REM};
        s1         = op1_signed & Operand1[WIDTH-1];
        s2         = op2_signed & Operand2[WIDTH-1];
        start_neg  = (MCycleOp inside {OP_REM, OP_REMU}) ? s1 : (s1 ^ s2);
        start_ovf  = (MCycleOp inside {OP_DIV, OP_REM}) &&
                     (Operand1 == WIDTH'(OVF_DIVIDEND)) &&
                     (Operand2 == WIDTH'(OVF_DIVISOR));
    end

    mcycle_negate #(.W(WIDTH)) u_abs1 (.val_i(Operand1), .neg_i(s1), .val_o(abs1));
    mcycle_negate #(.W(WIDTH)) u_abs2 (.val_i(Operand2), .neg_i(s2), .val_o(abs2));

    // One iteration of each algorithm; acc_q is {high/remainder, low/quotient}
    logic [WIDTH-1:0]   mul_addend, div_diff, rem_nx;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic               div_ok;
    logic [2*WIDTH-1:0] mul_acc_d, div_acc_d;

    always_comb begin
        mul_addend = b_q[0] ? a_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_acc_d  = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh     = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_ok     = rem_sh >= {1'b0, b_q};
        div_diff   = rem_sh[WIDTH-1:0] - b_q;
        rem_nx     = div_ok ? div_diff : rem_sh[WIDTH-1:0];
        div_acc_d  = {rem_nx, acc_q[WIDTH-2:0], div_ok};
    end

    // Sign fix-up: full product for multiplies, selected half for divides
    logic [2*WIDTH-1:0] fix_in, fix_out;
    logic [WIDTH-1:0]   fin_res;

    always_comb begin
        if (!op_q[2]) begin
            fix_in = acc_q;
        end else begin
            fix_in = {{WIDTH{1'b0}}, (op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0])};
        end
    end

    mcycle_negate #(.W(2*WIDTH)) u_fix (.val_i(fix_in), .neg_i(neg_q), .val_o(fix_out));

    always_comb begin
        fin_res = fix_out[WIDTH-1:0];
        case (op_q)
            OP_MUL:                       fin_res = fix_out[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = fix_out[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU: begin
                if (div0_q)      fin_res = WIDTH'(DIV0_QUOT);
                else if (ovf_q)  fin_res = WIDTH'(OVF_DIVIDEND);
                else             fin_res = fix_out[WIDTH-1:0];
            end
            default: begin
                if (div0_q)      fin_res = op1_q;
                else if (ovf_q)  fin_res = '0;
                else             fin_res = fix_out[WIDTH-1:0];
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op1_q    <= '0;
            wb_res_q <= '0;
            result_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // wb_q marks the writeback cycle; Busy is still high, so Start is ignored
                    if (wb_q) begin
                        result_q <= wb_res_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        wb_q     <= 1'b0;
                    end else if (Start) begin
                        op_q    <= MCycleOp;
                        neg_q   <= start_neg;
                        div0_q  <= (Operand2 == '0);
                        ovf_q   <= start_ovf;
                        a_q     <= abs1;
                        b_q     <= abs2;
                        op1_q   <= Operand1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (op_q[2]) begin
                        acc_q <= div_acc_d;
                        a_q   <= {a_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_q <= mul_acc_d;
                        b_q   <= {1'b0, b_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CW'(WIDTH-1)) state_q <= FINISH;
                end
                FINISH: begin
                    wb_res_q <= fin_res;
                    wb_q     <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Result = result_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule
